comma_aligner: RTL



---
 rtl/serdes_pkg.sv | 29 ++
 rtl/comma_detect.sv | 18 +
 rtl/comma_aligner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: alignment state enum, comma prefixes, symbol width
// and the window/comma helper functions used by the word aligner.
package serdes_pkg;

  localparam int SYM_W = 10;
  localparam int OFF_W = 4;

  localparam logic [6:0] COMMA_P7 = 7'b0011111;
  localparam logic [6:0] COMMA_N7 = 7'b1100000;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    CANDIDATE = 2'd1,
    LOCKED    = 2'd2
  } align_state_t;

  // Candidate symbol at offset off: cat[19-off -: 10], i.e. cat shifted down by 10-off.
  function automatic logic [SYM_W-1:0] cand_sym(input logic [2*SYM_W-1:0] cat,
                                                input logic [OFF_W-1:0]   off);
    logic [2*SYM_W-1:0] sh;
    sh = cat >> (5'd10 - {1'b0, off});
    return sh[SYM_W-1:0];
  endfunction

  function automatic logic is_comma(input logic [SYM_W-1:0] sym);
    return (sym[SYM_W-1 -: 7] == COMMA_P7) || (sym[SYM_W-1 -: 7] == COMMA_N7);
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma scan: flags every one of the 10 bit offsets of the
// 20-bit history window whose candidate symbol starts with a comma prefix.
module comma_detect
  import serdes_pkg::*;
(
  input  logic [2*SYM_W-1:0] cat,
  output logic [SYM_W-1:0]   hit
);

  // One comparator per offset
  always_comb begin
    hit = {SYM_W{1'b0}};
    for (int o = 0; o < SYM_W; o++) begin
      hit[o] = is_comma(cand_sym(cat, OFF_W'(o)));
    end
  end

endmodule

// File: rtl/comma_aligner.sv
// 8b/10b receive word aligner: finds comma offset, locks after LOCK_CNT commas.
// Optional feature macro ALIGNER_REALIGN_EN enables relock on MISALIGN_CNT misaligned commas.
module comma_aligner
  import serdes_pkg::*;
#(
  parameter int LOCK_CNT     = 3,
  parameter int MISALIGN_CNT = 2
) (
  input  logic             BitCLK_10,
  input  logic             Reset,
  input  logic [SYM_W-1:0] RxUnaligned_10,
  output logic [SYM_W-1:0] RxParallel_10,
  output logic             CommaDet,
  output logic             Locked,
  output logic [OFF_W-1:0] AlignOffset
);

  if ((LOCK_CNT < 1) || (LOCK_CNT > 15)) begin : g_bad_lock_cnt
    $error("comma_aligner: LOCK_CNT must be 1..15");
  end
  if ((MISALIGN_CNT < 1) || (MISALIGN_CNT > 15)) begin : g_bad_misalign_cnt
    $error("comma_aligner: MISALIGN_CNT must be 1..15");
  end

  localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);

  logic [SYM_W-1:0]   w0_r, w1_r;
  logic [2*SYM_W-1:0] cat_s;
  logic [SYM_W-1:0]   hit_s;
  align_state_t       state_r, state_s;
  logic [OFF_W-1:0]   off_r, off_s, low_s, sel_s;
  logic [3:0]         cnt_r, cnt_s, cnt_inc_s;
  logic               any_hit_s, cur_hit_s;
  logic [SYM_W-1:0]   rx_r, rx_s;
  logic               comma_r, comma_s, locked_r, locked_s;

`ifdef ALIGNER_REALIGN_EN
  localparam logic [3:0] MIS_TH = 4'(MISALIGN_CNT);
  logic [3:0] mcnt_r, mcnt_s, mcnt_inc_s;
`endif

  assign cat_s = {w0_r, w1_r};

  comma_detect u_comma_detect (
    .cat (cat_s),
    .hit (hit_s)
  );

  // Offset selection: keep the current offset while it still hits, else lowest hit
  always_comb begin
    low_s = 4'd0;
    for (int o = SYM_W - 1; o >= 0; o--) begin
      low_s = hit_s[o] ? OFF_W'(o) : low_s;
    end
    any_hit_s = |hit_s;
    cur_hit_s = hit_s[off_r];
    sel_s     = cur_hit_s ? off_r : low_s;
    cnt_inc_s = (cnt_r == 4'hF) ? cnt_r : (cnt_r + 4'd1);
  end

  // Alignment FSM next state plus next output word (new offset applies to this word)
  always_comb begin
    state_s = state_r;
    off_s   = off_r;
    cnt_s   = cnt_r;
`ifdef ALIGNER_REALIGN_EN
    mcnt_s     = mcnt_r;
    mcnt_inc_s = (mcnt_r == 4'hF) ? mcnt_r : (mcnt_r + 4'd1);
`endif
    case (state_r)
      UNLOCKED: begin
        if (any_hit_s) begin
          off_s   = sel_s;
          cnt_s   = 4'd1;
          state_s = (LOCK_TH == 4'd1) ? LOCKED : CANDIDATE;
        end else begin
          state_s = UNLOCKED;
        end
      end
      CANDIDATE: begin
        if (cur_hit_s) begin
          cnt_s   = cnt_inc_s;
          state_s = (cnt_inc_s >= LOCK_TH) ? LOCKED : CANDIDATE;
        end else if (any_hit_s) begin
          off_s = sel_s;
          cnt_s = 4'd1;
        end else begin
          state_s = CANDIDATE;
        end
      end
      LOCKED: begin
`ifdef ALIGNER_REALIGN_EN
        if (cur_hit_s) begin
          mcnt_s = 4'd0;
        end else if (any_hit_s) begin
          if (mcnt_inc_s >= MIS_TH) begin
            state_s = CANDIDATE;
            off_s   = sel_s;
            cnt_s   = 4'd1;
            mcnt_s  = 4'd0;
          end else begin
            mcnt_s = mcnt_inc_s;
          end
        end else begin
          mcnt_s = mcnt_r;
        end
`else
        state_s = LOCKED;
`endif
      end
      default: begin
        state_s = UNLOCKED;
        off_s   = 4'd0;
        cnt_s   = 4'd0;
      end
    endcase
    rx_s     = cand_sym(cat_s, off_s);
    comma_s  = hit_s[off_s];
    locked_s = (state_s == LOCKED);
  end

  // History, FSM state and registered outputs
  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      w0_r     <= 10'd0;
      w1_r     <= 10'd0;
      state_r  <= UNLOCKED;
      off_r    <= 4'd0;
      cnt_r    <= 4'd0;
      rx_r     <= 10'd0;
      comma_r  <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      w0_r     <= w1_r;
      w1_r     <= RxUnaligned_10;
      state_r  <= state_s;
      off_r    <= off_s;
      cnt_r    <= cnt_s;
      rx_r     <= rx_s;
      comma_r  <= comma_s;
      locked_r <= locked_s;
    end
  end

`ifdef ALIGNER_REALIGN_EN
  // Misaligned-comma counter, only present with realignment
  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      mcnt_r <= 4'd0;
    end else begin
      mcnt_r <= mcnt_s;
    end
  end
`endif

  assign RxParallel_10 = rx_r;
  assign CommaDet      = comma_r;
  assign Locked        = locked_r;
  assign AlignOffset   = off_r;

endmodule
